// File: rtl/imm_gen_if.sv
// Handshake bundle for imm_gen_pipe: instruction in, immediate out.
// The master side drives the instruction stream and the output ready; the slave side is the generator.
interface imm_gen_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
);
  logic             instr_valid_i;
  logic             instr_ready_o;
  logic [31:0]      instruction_i;
  logic             imm_valid_o;
  logic             imm_ready_i;
  logic [XLEN-1:0]  immediate_o;
  logic [2:0]       imm_fmt_o;
  logic             illegal_o;
  logic [CNT_W-1:0] illegal_cnt_o;

  modport master (
    output instr_valid_i, instruction_i, imm_ready_i,
    input  instr_ready_o, imm_valid_o, immediate_o, imm_fmt_o, illegal_o, illegal_cnt_o
  );

  modport slave (
    input  instr_valid_i, instruction_i, imm_ready_i,
    output instr_ready_o, imm_valid_o, immediate_o, imm_fmt_o, illegal_o, illegal_cnt_o
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV32I immediate generator with a 2-entry skid buffer and saturating illegal-opcode counter.
// Optional macro IMM_GEN_SHAMT_EN: shift-immediates return the zero-extended shamt only.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush_i,
  imm_gen_if.slave bus
);
  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } ent_t;

  ent_t             dec, main_q, main_d, skid_q, skid_d;
  logic             main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic             rdy_q, rdy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      inst, imm32;
  logic [6:0]       op;
  logic             s, acc, xfer;

  assign inst = bus.instruction_i;
  assign op   = inst[6:0];
  assign s    = inst[31];
  assign acc  = bus.instr_valid_i && rdy_q;
  assign xfer = main_vld_q && bus.imm_ready_i;

  always_comb begin
    imm32   = '0;
    dec     = '0;
    dec.fmt = FMT_NONE;
    case (op)
      7'h13, 7'h03, 7'h67: begin imm32 = {{20{s}}, inst[31:20]};                                dec.fmt = FMT_I; end
      7'h23:               begin imm32 = {{20{s}}, inst[31:25], inst[11:7]};                    dec.fmt = FMT_S; end
      7'h63:               begin imm32 = {{19{s}}, s, inst[7], inst[30:25], inst[11:8], 1'b0};  dec.fmt = FMT_B; end
      7'h37, 7'h17:        begin imm32 = {inst[31:12], 12'h000};                                dec.fmt = FMT_U; end
      7'h6F:               begin imm32 = {{11{s}}, s, inst[19:12], inst[20], inst[30:21], 1'b0}; dec.fmt = FMT_J; end
      7'h33:               ;
      default:             dec.ill = 1'b1;
    endcase
    // Widen by replicating bit 31 into every bit above the 32-bit result.
    dec.imm       = {XLEN{imm32[31]}};
    dec.imm[31:0] = imm32;
`ifdef IMM_GEN_SHAMT_EN
    if (op == 7'h13 && inst[13:12] == 2'b01) begin
      dec.imm = '0;
      if (XLEN == 64) dec.imm[5:0] = inst[25:20];
      else            dec.imm[4:0] = inst[24:20];
    end
`endif
  end

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush_i) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (xfer) begin
      // Skid full implies ready was low, so no accept can collide with the refill.
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (acc) begin
        main_d = dec;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (!main_vld_q) begin
      if (acc) begin
        main_d     = dec;
        main_vld_d = 1'b1;
      end
    end else if (acc) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
    rdy_d = !skid_vld_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (acc && dec.ill && !flush_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.instr_ready_o = rdy_q;
  assign bus.imm_valid_o   = main_vld_q;
  assign bus.immediate_o   = main_q.imm;
  assign bus.imm_fmt_o     = main_q.fmt;
  assign bus.illegal_o     = main_q.ill;
  assign bus.illegal_cnt_o = cnt_q;
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the RISC-V datapath; successor to the single-format combinational sign-extender. It decodes all RV32I immediate formats (I, S, B, U, J) from a 32-bit instruction, sign-extends the result to XLEN, and flags unsupported opcodes. It sits between instruction fetch/decode and the ALU operand mux. A valid/ready handshake with a 2-entry skid buffer gives one cycle of latency and full throughput under backpressure.

Parameters:
XLEN, 32, immediate output width (32 or 64); all sign extension fills to XLEN.
CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
flush_i  input  1  synchronous flush; drops all buffered entries.
instr_valid_i  input  1  instruction_i is valid.
instr_ready_o  output  1  block can accept an instruction this cycle.
instruction_i  input  32  raw instruction word.
imm_valid_o  output  1  immediate_o, imm_fmt_o and illegal_o are valid.
imm_ready_i  input  1  consumer accepts the output this cycle.
immediate_o  output  XLEN  constructed immediate.
imm_fmt_o  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
illegal_o  output  1  opcode not in the supported set.
illegal_cnt_o  output  CNT_W  saturating count of accepted illegal opcodes.

Behaviour:
- Reset (reset=0, async): both buffer entries empty; imm_valid_o=0; immediate_o=0; imm_fmt_o=0; illegal_o=0; illegal_cnt_o=0; instr_ready_o=1 after reset releases.
- Decode, with op = instruction_i[6:0] and s = instruction_i[31]:
  - I format, op 0x13/0x03/0x67: imm = sext(inst[31:20]).
  - S format, op 0x23: imm = sext({inst[31:25], inst[11:7]}).
  - B format, op 0x63: imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U format, op 0x37/0x17: imm = sext({inst[31:12], 12'h000}). For XLEN=64, bit 31 fills bits 63:32.
  - J format, op 0x6F: imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - op 0x33 (R format): imm = 0, fmt NONE, illegal=0.
  - Any other op: imm = 0, fmt NONE, illegal=1.
- Handshake:
  - Accept occurs when instr_valid_i && instr_ready_o.
  - Output transfer occurs when imm_valid_o && imm_ready_i.
  - Results are decoded at accept and registered; they appear on the outputs the next cycle (latency 1).
- Skid buffer (main + skid entry):
  - instr_ready_o = !skid_full, driven from a register (no combinational path from imm_ready_i).
  - Accept while main is empty, or main is being transferred in the same cycle: data goes to main.
  - Accept while main is held (imm_valid_o && !imm_ready_i): data goes to skid, instr_ready_o drops next cycle.
  - On transfer with skid full: skid moves to main and instr_ready_o rises.
  - Order is preserved; no entry is lost or duplicated.
  - Outputs stay stable while imm_valid_o && !imm_ready_i.
- Full throughput: with imm_ready_i held at 1, one instruction per cycle is accepted and delivered.
- flush_i=1: both entries are cleared at the next edge and imm_valid_o=0. An input accepted in the same cycle is discarded. Flush has priority over accept and transfer. illegal_cnt_o is not cleared by flush.
- illegal_cnt_o:
  - Increments on each accept with illegal=1, unless flush_i is high in the same cycle.
  - Saturates at all-ones.
- Reset asserted mid-transfer empties the buffer immediately; the pending output is lost.

Optional Feature:
Macro IMM_GEN_SHAMT_EN.
- Defined: for op 0x13 with funct3 001 or 101, immediate_o = zero-extended shamt. shamt is inst[24:20] for XLEN=32 and inst[25:20] for XLEN=64. funct7 bits are masked. fmt = I.
- Undefined: shift-immediates use the plain I rule, so funct7 bits appear in immediate_o.

Test Plan:
- Send 0xFFF00093 (addi x1,x0,-1) with imm_ready_i=1 -> next cycle imm_valid_o=1, immediate_o=0xFFFFFFFF, fmt=1, illegal_o=0.
- Send 0x123450B7 (lui) then 0x00112623 (sw x1,12(x2)) back-to-back -> immediate_o=0x12345000 fmt=4, then 0x0000000C fmt=2, on consecutive cycles.
- Send 0xFE000EE3 (beq -4) with XLEN=64 -> immediate_o=0xFFFFFFFFFFFFFFFC, fmt=3.
- Hold imm_ready_i=0 and offer 3 instructions -> 2 accepted, then instr_ready_o=0. Release imm_ready_i -> 3rd instruction accepted; outputs appear in order, none dropped.
- Send 0x0000007F twice -> illegal_o=1, immediate_o=0, illegal_cnt_o=2. Pulse flush_i with one entry held -> imm_valid_o=0, count stays 2. Assert reset -> count 0.
- Send 0x4030D093 (srai x1,x1,3) -> with IMM_GEN_SHAMT_EN, immediate_o=0x00000003; without it, immediate_o=0x00000403.
